// File: rtl/regfile_rport_if.sv
// Operand-fetch read interface between decode (master) and the register file (slave).
// Each *_info carries {en, addr}; *_data returns the resolved operand.
interface regfile_rport_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [ADDR_W:0]   r1_info;
  logic [DATA_W-1:0] r1_data;
  logic [ADDR_W:0]   r2_info;
  logic [DATA_W-1:0] r2_data;

  modport master (output r1_info, r2_info, input  r1_data, r2_data);
  modport slave  (input  r1_info, r2_info, output r1_data, r2_data);
endinterface

// File: rtl/regfile_rport.sv
// MIPS GPR file: two combinational read ports with write-back bypass, one write port,
// and a pending-write scoreboard that decode uses to stall on load-use hazards.
module regfile_rport #(
  parameter int NUM_REGS  = 32,
  parameter int ADDR_W    = 5,   // 2**ADDR_W must equal NUM_REGS
  parameter int DATA_W    = 32,
  parameter int BYPASS_EN = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  regfile_rport_if.slave           fetch,
  input  logic [ADDR_W+DATA_W:0]   wb_wreg_i,
  input  logic [ADDR_W:0]          sb_set_i,
  output logic                     r1_busy_o,
  output logic                     r2_busy_o,
  output logic [NUM_REGS-1:0]      pending_o
);

  localparam logic RST_ENABLE = 1'b0;

  logic              rst_off;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              sb_en;
  logic [ADDR_W-1:0] sb_addr;
  logic              wr_ok;
  logic              set_ok;

  logic              r1_en, r2_en;
  logic [ADDR_W-1:0] r1_addr, r2_addr;
  logic              r1_hit, r2_hit;
  logic              r1_ok, r2_ok;

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;

  assign rst_off                   = (rst != RST_ENABLE);
  assign {wb_en, wb_addr, wb_data} = wb_wreg_i;
  assign {sb_en, sb_addr}          = sb_set_i;
  assign {r1_en, r1_addr}          = fetch.r1_info;
  assign {r2_en, r2_addr}          = fetch.r2_info;

  assign wr_ok  = wb_en && (wb_addr != '0);
  assign set_ok = sb_en && (sb_addr != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      pending_q <= '0;
    end else begin
      if (wr_ok) regs_q[wb_addr] <= wb_data;
      pending_q <= pending_d;
    end
  end

  // Set is applied after clear so a reissued load to the same destination stays pending.
  always_comb begin
    pending_d = pending_q;
    if (wr_ok)  pending_d[wb_addr] = 1'b0;
    if (set_ok) pending_d[sb_addr] = 1'b1;
    pending_d[0] = 1'b0;
  end

  assign r1_hit = (BYPASS_EN != 0) && wb_en && (wb_addr == r1_addr);
  assign r2_hit = (BYPASS_EN != 0) && wb_en && (wb_addr == r2_addr);
  assign r1_ok  = rst_off && r1_en && (r1_addr != '0);
  assign r2_ok  = rst_off && r2_en && (r2_addr != '0);

  // Reset gating keeps outputs at zero even while write-back inputs are still active.
  assign fetch.r1_data = !r1_ok ? '0 : (r1_hit ? wb_data : regs_q[r1_addr]);
  assign fetch.r2_data = !r2_ok ? '0 : (r2_hit ? wb_data : regs_q[r2_addr]);

  assign r1_busy_o = r1_ok && pending_q[r1_addr] && !r1_hit;
  assign r2_busy_o = r2_ok && pending_q[r2_addr] && !r2_hit;
  assign pending_o = pending_q;

endmodule

// File: tb/tb_regfile_rport.sv
// Directed and model-checked bench for regfile_rport; runs a bypassing and a
// non-bypassing instance side by side on identical stimulus.
module tb_regfile_rport;

  logic        clk = 1'b0;
  logic        rst;
  logic [37:0] wb;
  logic [5:0]  sb;
  logic        ba1, ba2, bb1, bb2;
  logic [31:0] pa, pb;

  int checks = 0;
  int errors = 0;

  logic [31:0] mregs [32];
  logic [31:0] mpend;

  regfile_rport_if #(.ADDR_W(5), .DATA_W(32)) ifa ();
  regfile_rport_if #(.ADDR_W(5), .DATA_W(32)) ifb ();

  regfile_rport #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .BYPASS_EN(1)) dut_a (
    .clk(clk), .rst(rst), .fetch(ifa.slave), .wb_wreg_i(wb), .sb_set_i(sb),
    .r1_busy_o(ba1), .r2_busy_o(ba2), .pending_o(pa)
  );

  regfile_rport #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .BYPASS_EN(0)) dut_b (
    .clk(clk), .rst(rst), .fetch(ifb.slave), .wb_wreg_i(wb), .sb_set_i(sb),
    .r1_busy_o(bb1), .r2_busy_o(bb2), .pending_o(pb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2);
    ifa.r1_info = {e1, a1};
    ifa.r2_info = {e2, a2};
    ifb.r1_info = {e1, a1};
    ifb.r2_info = {e2, a2};
    #2;
  endtask

  function automatic logic [31:0] exp_rd(input bit byp, input logic [5:0] info);
    if (!info[5] || info[4:0] == 5'd0) return 32'h0;
    if (byp && wb[37] && wb[36:32] == info[4:0]) return wb[31:0];
    return mregs[info[4:0]];
  endfunction

  function automatic logic exp_busy(input bit byp, input logic [5:0] info);
    if (!info[5] || info[4:0] == 5'd0) return 1'b0;
    if (byp && wb[37] && wb[36:32] == info[4:0]) return 1'b0;
    return mpend[info[4:0]];
  endfunction

  initial begin
    rst = 1'b0;
    wb  = '0;
    sb  = '0;
    rd(1'b0, 5'd0, 1'b0, 5'd0);

    // Reset state, with write/set inputs active that must be ignored
    wb = {1'b1, 5'd5, 32'h1111_2222};
    sb = {1'b1, 5'd6};
    rd(1'b1, 5'd5, 1'b1, 5'd6);
    check("rst_r1_data", ifa.r1_data, 32'h0);
    check("rst_r1_busy", ba1, 1'b0);
    check("rst_pending", pa, 32'h0);
    tick();
    check("rst_pending_after_edge", pa, 32'h0);
    rst = 1'b1;
    wb  = '0;
    sb  = '0;
    tick();
    rd(1'b1, 5'd5, 1'b1, 5'd6);
    check("rst_reg5_not_written", ifa.r1_data, 32'h0);

    // Write reg5, then assert reset asynchronously mid-cycle
    wb = {1'b1, 5'd5, 32'hDEAD_BEEF};
    tick();
    wb = '0;
    rd(1'b1, 5'd5, 1'b0, 5'd0);
    check("wr_reg5", ifa.r1_data, 32'hDEAD_BEEF);
    rst = 1'b0;
    #1;
    check("async_rst_r1_data", ifa.r1_data, 32'h0);
    tick();
    rst = 1'b1;
    tick();
    rd(1'b1, 5'd5, 1'b0, 5'd0);
    check("reg5_cleared", ifa.r1_data, 32'h0);

    // Writes to register 0 are dropped
    wb = {1'b1, 5'd0, 32'h0000_1234};
    rd(1'b1, 5'd0, 1'b1, 5'd0);
    check("reg0_bypass_blocked", ifa.r1_data, 32'h0);
    tick();
    wb = '0;
    rd(1'b1, 5'd0, 1'b1, 5'd0);
    check("reg0_read", ifa.r1_data, 32'h0);
    check("reg0_read_r2", ifa.r2_data, 32'h0);

    // Write then read on both ports; disabled port returns zero
    wb = {1'b1, 5'd7, 32'hA5A5_0001};
    tick();
    wb = '0;
    rd(1'b1, 5'd7, 1'b1, 5'd7);
    check("wr7_r1", ifa.r1_data, 32'hA5A5_0001);
    check("wr7_r2", ifa.r2_data, 32'hA5A5_0001);
    check("wr7_nobyp_r1", ifb.r1_data, 32'hA5A5_0001);
    rd(1'b0, 5'd7, 1'b1, 5'd7);
    check("en0_r1", ifa.r1_data, 32'h0);

    // Bypass versus stored value
    wb = {1'b1, 5'd4, 32'h0000_0009};
    tick();
    wb = {1'b1, 5'd3, 32'h0000_0011};
    tick();
    wb = {1'b1, 5'd3, 32'h0000_0055};
    rd(1'b1, 5'd3, 1'b1, 5'd4);
    check("byp_r1", ifa.r1_data, 32'h55);
    check("byp_r2", ifa.r2_data, 32'h9);
    check("nobyp_r1_old", ifb.r1_data, 32'h11);
    check("nobyp_r2", ifb.r2_data, 32'h9);
    tick();
    wb = '0;
    #2;
    check("nobyp_r1_next", ifb.r1_data, 32'h55);

    // Load-use busy and its release in the write-back cycle
    sb = {1'b1, 5'd8};
    tick();
    sb = '0;
    rd(1'b1, 5'd8, 1'b0, 5'd0);
    check("busy_set_a", ba1, 1'b1);
    check("busy_set_b", bb1, 1'b1);
    check("pend8_set", pa[8], 1'b1);
    tick();
    tick();
    check("busy_hold", ba1, 1'b1);
    wb = {1'b1, 5'd8, 32'h0000_0077};
    #2;
    check("busy_wb_a", ba1, 1'b0);
    check("data_wb_a", ifa.r1_data, 32'h77);
    check("busy_wb_b", bb1, 1'b1);
    check("pend8_pre_edge", pa[8], 1'b1);
    tick();
    wb = '0;
    #2;
    check("pend8_clr_a", pa[8], 1'b0);
    check("pend8_clr_b", pb[8], 1'b0);
    check("busy_after_b", bb1, 1'b0);
    check("data_after_b", ifb.r1_data, 32'h77);

    // Simultaneous set and clear
    sb = {1'b1, 5'd9};
    wb = {1'b1, 5'd9, 32'h0000_0001};
    tick();
    check("set_wins_9", pa[9], 1'b1);
    sb = {1'b1, 5'd11};
    wb = '0;
    tick();
    sb = {1'b1, 5'd10};
    wb = {1'b1, 5'd11, 32'h0000_0002};
    tick();
    check("diff_set_10", pa[10], 1'b1);
    check("diff_clr_11", pa[11], 1'b0);
    check("pend_vec", pa, 32'h0000_0600);
    sb = {1'b1, 5'd0};
    wb = '0;
    tick();
    check("pend0_never_set", pa[0], 1'b0);
    sb = '0;

    // Model-checked random traffic from a fresh reset
    rst = 1'b0;
    #2;
    rst = 1'b1;
    tick();
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    mpend = 32'h0;
    for (int n = 0; n < 2000; n++) begin
      wb = {($urandom_range(0, 1) == 1), 5'($urandom_range(0, 15)), 32'($urandom)};
      sb = {($urandom_range(0, 3) == 0), 5'($urandom_range(0, 15))};
      rd(($urandom_range(0, 7) != 0), 5'($urandom_range(0, 15)),
         ($urandom_range(0, 7) != 0), 5'($urandom_range(0, 15)));
      check("rnd_a_r1", ifa.r1_data, exp_rd(1'b1, ifa.r1_info));
      check("rnd_a_r2", ifa.r2_data, exp_rd(1'b1, ifa.r2_info));
      check("rnd_b_r1", ifb.r1_data, exp_rd(1'b0, ifb.r1_info));
      check("rnd_b_r2", ifb.r2_data, exp_rd(1'b0, ifb.r2_info));
      check("rnd_a_busy1", ba1, exp_busy(1'b1, ifa.r1_info));
      check("rnd_a_busy2", ba2, exp_busy(1'b1, ifa.r2_info));
      check("rnd_b_busy1", bb1, exp_busy(1'b0, ifb.r1_info));
      check("rnd_b_busy2", bb2, exp_busy(1'b0, ifb.r2_info));
      check("rnd_a_pend", pa, mpend);
      check("rnd_b_pend", pb, mpend);
      check("rnd_pend0", pa[0], 1'b0);
      if (wb[37] && wb[36:32] != 5'd0) begin
        mregs[wb[36:32]] = wb[31:0];
        mpend[wb[36:32]] = 1'b0;
      end
      if (sb[5] && sb[4:0] != 5'd0) mpend[sb[4:0]] = 1'b1;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
